// File: rtl/sudoku_pkg.sv
// Shared constants, error codes, FSM state and cell coordinate tag for the Sudoku solver/checker.
// Combinational helpers only; no latency, no backpressure.
package sudoku_pkg;

    localparam int N_CELLS  = 81;
    localparam int GRID_DIM = 9;
    localparam int BOX_DIM  = 3;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_VAL  = 3'd1;
    localparam logic [2:0] ERR_ROW  = 3'd2;
    localparam logic [2:0] ERR_COL  = 3'd3;
    localparam logic [2:0] ERR_BOX  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sudoku_state_e;

    typedef struct packed {
        logic [6:0] idx;
        logic [3:0] row;
        logic [3:0] col;
        logic [3:0] box;
    } cell_tag_t;

    // Digit v (1..9) maps to mask bit v-1.
    function automatic logic [GRID_DIM-1:0] digit_bit(input logic [3:0] d);
        return GRID_DIM'(1) << (d - 4'd1);
    endfunction

endpackage

// File: rtl/sudoku_coord_cnt.sv
// Row-major cell walker producing index/row/col/box incrementally (no divider).
// Tag updates the cycle after en; clr wins over en; wraps to cell 0 after the last cell.
module sudoku_coord_cnt
    import sudoku_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      en,
    output cell_tag_t tag,
    output logic      last
);

    localparam logic [6:0] IDX_LAST = 7'(N_CELLS - 1);
    localparam logic [3:0] DIM_LAST = 4'(GRID_DIM - 1);
    localparam logic [3:0] BAND_0   = 4'(BOX_DIM - 1);
    localparam logic [3:0] BAND_1   = 4'(2 * BOX_DIM - 1);
    localparam logic [3:0] BOX_BACK = 4'(BOX_DIM - 1);

    cell_tag_t tag_q;
    cell_tag_t tag_d;

    always_comb begin
        tag_d = tag_q;
        if (clr || (en && (tag_q.idx == IDX_LAST))) begin
            tag_d = '0;
        end else if (en) begin
            tag_d.idx = tag_q.idx + 7'd1;
            if (tag_q.col == DIM_LAST) begin
                // End of a row: step down one row; box moves to the next band or back to its band start.
                tag_d.col = '0;
                tag_d.row = tag_q.row + 4'd1;
                if ((tag_q.row == BAND_0) || (tag_q.row == BAND_1)) begin
                    tag_d.box = tag_q.box + 4'd1;
                end else begin
                    tag_d.box = tag_q.box - BOX_BACK;
                end
            end else begin
                tag_d.col = tag_q.col + 4'd1;
                if ((tag_q.col == BAND_0) || (tag_q.col == BAND_1)) begin
                    tag_d.box = tag_q.box + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag  = tag_q;
    assign last = (tag_q.idx == IDX_LAST);

endmodule

// File: rtl/sudoku_checker.sv
// Reads back the 81-cell result RAM and checks every row/column/box holds 1..9 once.
// Fixed latency: result valid 82+RD_LAT cycles after start; no backpressure, start ignored while busy.
module sudoku_checker
    import sudoku_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 7,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          RAM_ceb,
    output logic          RAM_web,
    output logic [AW-1:0] RAM_A,
    input  logic [DW-1:0] RAM_Q,
    output logic          busy,
    output logic          valid,
    output logic          pass,
    output logic [6:0]    err_idx,
    output logic [2:0]    err_code
);

    localparam logic [6:0] IDX_LAST = 7'(N_CELLS - 1);

    sudoku_state_e state_q;
    sudoku_state_e state_d;
    logic          start_acc;
    logic          cnt_en;
    logic          cnt_last;
    cell_tag_t     cnt_tag;

    logic      [RD_LAT-1:0] pipe_vld_q;
    logic      [RD_LAT-1:0] pipe_vld_d;
    cell_tag_t [RD_LAT-1:0] pipe_tag_q;
    cell_tag_t [RD_LAT-1:0] pipe_tag_d;
    logic                   chk_vld;
    cell_tag_t              chk_tag;

    logic [GRID_DIM-1:0][GRID_DIM-1:0] row_m_q;
    logic [GRID_DIM-1:0][GRID_DIM-1:0] row_m_d;
    logic [GRID_DIM-1:0][GRID_DIM-1:0] col_m_q;
    logic [GRID_DIM-1:0][GRID_DIM-1:0] col_m_d;
    logic [GRID_DIM-1:0][GRID_DIM-1:0] box_m_q;
    logic [GRID_DIM-1:0][GRID_DIM-1:0] box_m_d;

    logic [6:0]          err_idx_q;
    logic [6:0]          err_idx_d;
    logic [2:0]          err_code_q;
    logic [2:0]          err_code_d;
    logic                bad_val;
    logic [GRID_DIM-1:0] dbit;
    logic [2:0]          cell_code;

    sudoku_coord_cnt u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .en   (cnt_en),
        .tag  (cnt_tag),
        .last (cnt_last)
    );

    assign chk_vld = pipe_vld_q[RD_LAT-1];
    assign chk_tag = pipe_tag_q[RD_LAT-1];

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (chk_vld && (chk_tag.idx == IDX_LAST)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The issue tag travels alongside the read so the check sees the coordinates of RAM_Q.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_tag_d    = pipe_tag_q;
        pipe_vld_d[0] = (state_q == ST_ISSUE);
        pipe_tag_d[0] = cnt_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    always_comb begin
        row_m_d    = row_m_q;
        col_m_d    = col_m_q;
        box_m_d    = box_m_q;
        err_idx_d  = err_idx_q;
        err_code_d = err_code_q;
        cell_code  = ERR_NONE;
        // The whole word counts for range: a set upper bit is illegal even if the low nibble looks fine.
        bad_val    = (RAM_Q == '0) || (RAM_Q > DW'(GRID_DIM));
        dbit       = digit_bit(RAM_Q[3:0]);

        if (bad_val) begin
            cell_code = ERR_VAL;
        end else if ((row_m_q[chk_tag.row] & dbit) != '0) begin
            cell_code = ERR_ROW;
        end else if ((col_m_q[chk_tag.col] & dbit) != '0) begin
            cell_code = ERR_COL;
        end else if ((box_m_q[chk_tag.box] & dbit) != '0) begin
            cell_code = ERR_BOX;
        end

        if (start_acc) begin
            row_m_d    = '0;
            col_m_d    = '0;
            box_m_d    = '0;
            err_idx_d  = '0;
            err_code_d = ERR_NONE;
        end else if (chk_vld) begin
            if (!bad_val) begin
                row_m_d[chk_tag.row] = row_m_q[chk_tag.row] | dbit;
                col_m_d[chk_tag.col] = col_m_q[chk_tag.col] | dbit;
                box_m_d[chk_tag.box] = box_m_q[chk_tag.box] | dbit;
            end
            // Only the first offending cell is kept; the scan still runs to the end.
            if ((err_code_q == ERR_NONE) && (cell_code != ERR_NONE)) begin
                err_idx_d  = chk_tag.idx;
                err_code_d = cell_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
            row_m_q    <= '0;
            col_m_q    <= '0;
            box_m_q    <= '0;
            err_idx_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_tag_q <= pipe_tag_d;
            row_m_q    <= row_m_d;
            col_m_q    <= col_m_d;
            box_m_q    <= box_m_d;
            err_idx_q  <= err_idx_d;
            err_code_q <= err_code_d;
        end
    end

    assign RAM_ceb  = (state_q == ST_ISSUE);
    assign RAM_web  = 1'b1;
    assign RAM_A    = AW'(cnt_tag.idx);
    assign busy     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign valid    = (state_q == ST_DONE);
    assign pass     = (state_q == ST_DONE) && (err_code_q == ERR_NONE);
    assign err_idx  = err_idx_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_sudoku_checker.sv
// Scoreboard bench: two checkers (RD_LAT=1 and RD_LAT=2) read a shared RAM model loaded with directed grids.
module tb_sudoku_checker;

    typedef struct {
        logic       pass;
        logic [2:0] code;
        logic [6:0] idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [81];
    logic       start [2];
    logic       rst [2];
    logic       idle_chk [2];
    logic       restart_chk [2];
    logic       busy [2];
    logic       valid [2];
    logic       pass [2];
    logic       ceb [2];
    logic       web [2];
    logic [6:0] ra [2];
    logic [7:0] rq [2];
    logic [6:0] eidx [2];
    logic [2:0] ecode [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] s1_q;
        logic [7:0] s2_q;
        always @(posedge clk) begin
            if (ceb[g]) s1_q <= mem[ra[g]];
            s2_q <= s1_q;
        end
        assign rq[g] = (g == 0) ? s1_q : s2_q;

        sudoku_checker #(.DW(8), .AW(7), .RD_LAT(g + 1)) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .start    (start[g]),
            .RAM_ceb  (ceb[g]),
            .RAM_web  (web[g]),
            .RAM_A    (ra[g]),
            .RAM_Q    (rq[g]),
            .busy     (busy[g]),
            .valid    (valid[g]),
            .pass     (pass[g]),
            .err_idx  (eidx[g]),
            .err_code (ecode[g])
        );
    end

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", name, i, cyc, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, mid-cycle.
    int   c0 [2]         = '{0, 0};
    int   busy_cnt [2]   = '{0, 0};
    logic valid_prev [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            chk("ram_web", i, int'(web[i]), 1);
            if (idle_chk[i]) begin
                chk("idle_busy", i, int'(busy[i]), 0);
                chk("idle_ceb", i, int'(ceb[i]), 0);
                chk("idle_valid", i, int'(valid[i]), 0);
                chk("idle_pass", i, int'(pass[i]), 0);
                chk("idle_addr", i, int'(ra[i]), 0);
                chk("idle_err_idx", i, int'(eidx[i]), 0);
                chk("idle_err_code", i, int'(ecode[i]), 0);
            end
            if (restart_chk[i]) begin
                chk("restart_valid", i, int'(valid[i]), 0);
                chk("restart_busy", i, int'(busy[i]), 1);
                chk("restart_pass", i, int'(pass[i]), 0);
                chk("restart_err_code", i, int'(ecode[i]), 0);
            end
            if (start[i] && !busy[i]) begin
                c0[i]       = cyc;
                busy_cnt[i] = 0;
            end
            if (busy[i]) busy_cnt[i]++;
            if (ceb[i]) chk("ram_addr", i, int'(ra[i]), cyc - c0[i] - 1);
            if (valid[i] && !valid_prev[i]) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    chk("spurious_valid", i, int'(valid[i]), 0);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("pass", i, int'(pass[i]), int'(e.pass));
                    chk("err_code", i, int'(ecode[i]), int'(e.code));
                    chk("err_idx", i, int'(eidx[i]), int'(e.idx));
                    chk("latency", i, cyc - c0[i], 83 + i);
                    chk("busy_cycles", i, busy_cnt[i], 82 + i);
                    chk("busy_at_valid", i, int'(busy[i]), 0);
                end
            end
            valid_prev[i] = valid[i];
        end
    end

    // Classic shifted-row solution: cell(r,c) = ((3r + r/3 + c) mod 9) + 1.
    task automatic load_grid();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                mem[r*9 + c] = 8'(((r*3 + r/3 + c) % 9) + 1);
    endtask

    task automatic expect_res(input int i, input logic p, input logic [2:0] code, input logic [6:0] idx);
        exp_t e;
        e.pass = p;
        e.code = code;
        e.idx  = idx;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Leaves the caller just after the edge that starts cycle 2.
    task automatic do_start(input int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0; restart_chk[i] = 1'b1;
        @(posedge clk); #1 restart_chk[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (!valid[i] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!valid[i]) begin
            $display("FAIL timeout dut%0d: valid=0 after %0d cycles, expected 1", i, n);
            $fatal(1, "checker never completed");
        end
    endtask

    task automatic run_one(input int i, input logic p, input logic [2:0] code, input logic [6:0] idx);
        expect_res(i, p, code, idx);
        do_start(i);
        wait_done(i);
        load_grid();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i]       = 1'b0;
            rst[i]         = 1'b1;
            idle_chk[i]    = 1'b0;
            restart_chk[i] = 1'b0;
        end
        load_grid();
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle_chk[0] = 1'b1; idle_chk[1] = 1'b1;
        @(posedge clk); #1;
        idle_chk[0] = 1'b0; idle_chk[1] = 1'b0;

        run_one(0, 1'b1, 3'd0, 7'd0);                       // legal grid
        mem[40] = 8'h00; run_one(0, 1'b0, 3'd1, 7'd40);     // zero value
        mem[5]  = 8'h0A; run_one(0, 1'b0, 3'd1, 7'd5);      // value above 9
        mem[7]  = 8'h13; run_one(0, 1'b0, 3'd1, 7'd7);      // upper bits set
        mem[80] = mem[72]; run_one(0, 1'b0, 3'd2, 7'd80);   // row dup, last cell
        mem[9]  = mem[0];  run_one(0, 1'b0, 3'd3, 7'd9);    // column dup
        mem[10] = mem[0];  run_one(0, 1'b0, 3'd4, 7'd10);   // box dup
        mem[3]  = 8'h00; mem[20] = mem[18];
        run_one(0, 1'b0, 3'd1, 7'd3);                       // first fault sticks

        // start during the scan is ignored
        expect_res(0, 1'b1, 3'd0, 7'd0);
        do_start(0);
        repeat (28) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0);

        // reset at cycle 40 aborts silently, then a fresh run
        do_start(0);
        repeat (38) @(posedge clk);
        #1 rst[0] = 1'b1;
        @(posedge clk); #1 rst[0] = 1'b0; idle_chk[0] = 1'b1;
        @(posedge clk); #1 idle_chk[0] = 1'b0;
        mem[9] = mem[0]; run_one(0, 1'b0, 3'd3, 7'd9);

        // two-cycle read latency
        run_one(1, 1'b1, 3'd0, 7'd0);
        mem[40] = 8'h00; run_one(1, 1'b0, 3'd1, 7'd40);
        mem[80] = mem[72]; run_one(1, 1'b0, 3'd2, 7'd80);

        repeat (3) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL pending_results: %0d/%0d outstanding, expected 0/0", q0.size(), q1.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
